pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 146 ++++++++++++++
 tb/tb_pc_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter with phase-sequenced update, trap/return/branch selection
// and a circular return-address stack that overwrites its oldest entry when full.
module pc_unit #(
  parameter int             W         = 32,
  parameter logic [W-1:0]   RESET_VEC = '0,
  parameter logic [W-1:0]   TRAP_VEC  = W'(32'h80),
  parameter int             RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [4:0]   phase,
  input  logic         stall,
  input  logic         ct_taken,
  input  logic [W-1:0] ct_target,
  input  logic         call,
  input  logic         ret,
  input  logic         trap,
  output logic [W-1:0] pc,
  output logic [W-1:0] ipc,
  output logic [W-1:0] epc,
  output logic         ras_empty,
  output logic         ras_full,
  output logic         ras_err,
  output logic         misalign,
  output logic         phase_err
);

  localparam int            AW       = $clog2(RAS_DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [W-1:0]  ras_mem [RAS_DEPTH];
  logic [AW-1:0] sp_reg, sp_next;        // sp_reg points at the next free slot
  logic [CW-1:0] count_reg, count_next;
  logic [W-1:0]  pc_reg, pc_next;
  logic [W-1:0]  ipc_reg, ipc_next;
  logic [W-1:0]  epc_reg, epc_next;
  logic          empty_reg, empty_next;
  logic          full_reg, full_next;
  logic          ras_err_reg, ras_err_next;
  logic          misalign_reg, misalign_next;
  logic          phase_err_reg, phase_err_next;
  logic          push;
  logic [W-1:0]  top;
  logic          tgt_bad;

  assign top     = ras_mem[sp_reg - AW'(1)];
  assign tgt_bad = (ct_target[1:0] != 2'b00);

  always_comb begin
    pc_next        = pc_reg;
    ipc_next       = ipc_reg;
    epc_next       = epc_reg;
    sp_next        = sp_reg;
    count_next     = count_reg;
    ras_err_next   = ras_err_reg;
    misalign_next  = misalign_reg;
    phase_err_next = phase_err_reg;
    push           = 1'b0;

    if (!stall) begin
      if (!$onehot(phase)) begin
        phase_err_next = 1'b1;
      end else if (phase[0]) begin
        ipc_next = pc_reg;
        pc_next  = pc_reg + W'(4);
      end else if (phase[4]) begin
        if (trap) begin
          pc_next  = TRAP_VEC;
          epc_next = ipc_reg;
        end else if (ret) begin
          if (count_reg != '0) begin
            pc_next    = top;
            sp_next    = sp_reg - AW'(1);
            count_next = count_reg - CW'(1);
          end else if (tgt_bad) begin
            pc_next       = TRAP_VEC;
            epc_next      = ipc_reg;
            misalign_next = 1'b1;
          end else begin
            pc_next      = ct_target;
            ras_err_next = 1'b1;
          end
        end else if (ct_taken) begin
          if (tgt_bad) begin
            pc_next       = TRAP_VEC;
            epc_next      = ipc_reg;
            misalign_next = 1'b1;
          end else begin
            pc_next = ct_target;
            if (call) begin
              // Full stack: the slot written next is the oldest one, so count saturates.
              push    = 1'b1;
              sp_next = sp_reg + AW'(1);
              if (count_reg != FULL_CNT) count_next = count_reg + CW'(1);
            end
          end
        end
      end
    end

    empty_next = (count_next == '0);
    full_next  = (count_next == FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pc_reg        <= RESET_VEC;
      ipc_reg       <= RESET_VEC;
      epc_reg       <= '0;
      sp_reg        <= '0;
      count_reg     <= '0;
      empty_reg     <= 1'b1;
      full_reg      <= 1'b0;
      ras_err_reg   <= 1'b0;
      misalign_reg  <= 1'b0;
      phase_err_reg <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      ipc_reg       <= ipc_next;
      epc_reg       <= epc_next;
      sp_reg        <= sp_next;
      count_reg     <= count_next;
      empty_reg     <= empty_next;
      full_reg      <= full_next;
      ras_err_reg   <= ras_err_next;
      misalign_reg  <= misalign_next;
      phase_err_reg <= phase_err_next;
    end
  end

  // The link is the pre-edge pc; a push coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (n_rst && push) ras_mem[sp_reg] <= pc_reg;
  end

  assign pc        = pc_reg;
  assign ipc       = ipc_reg;
  assign epc       = epc_reg;
  assign ras_empty = empty_reg;
  assign ras_full  = full_reg;
  assign ras_err   = ras_err_reg;
  assign misalign  = misalign_reg;
  assign phase_err = phase_err_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random
// stimulus, every edge compared against a queue-based reference model.
module tb_pc_unit;

  localparam logic [4:0] PF = 5'b00001, PR = 5'b00010, PX = 5'b00100,
                         PM = 5'b01000, PW = 5'b10000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [4:0]  phase;
  logic        stall, ct_taken, call, ret, trap;
  logic [31:0] ct_target;
  logic [31:0] pc, ipc, epc;
  logic        ras_empty, ras_full, ras_err, misalign, phase_err;

  logic [7:0]  s_pc, s_ipc, s_epc;
  logic        s_empty, s_full, s_err, s_mis, s_perr;
  logic        s_ct = 1'b0, s_call = 1'b0, s_ret = 1'b0, s_trap = 1'b0;
  logic [7:0]  s_tgt = 8'h00;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [31:0] m_pc, m_ipc, m_epc;
  logic        m_err, m_mis, m_perr;
  logic [31:0] m_stack[$];

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .n_rst(n_rst), .phase(phase), .stall(stall),
    .ct_taken(ct_taken), .ct_target(ct_target), .call(call), .ret(ret), .trap(trap),
    .pc(pc), .ipc(ipc), .epc(epc), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_err(ras_err), .misalign(misalign), .phase_err(phase_err)
  );

  pc_unit #(.W(8), .RESET_VEC(8'hF0), .TRAP_VEC(8'h80), .RAS_DEPTH(4)) dut8 (
    .clk(clk), .n_rst(n_rst), .phase(phase), .stall(stall),
    .ct_taken(s_ct), .ct_target(s_tgt), .call(s_call), .ret(s_ret), .trap(s_trap),
    .pc(s_pc), .ipc(s_ipc), .epc(s_epc), .ras_empty(s_empty), .ras_full(s_full),
    .ras_err(s_err), .misalign(s_mis), .phase_err(s_perr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!n_rst) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_epc = 32'h0;
      m_err = 1'b0; m_mis = 1'b0; m_perr = 1'b0;
      m_stack.delete();
      return;
    end
    if (stall) return;
    if ($countones(phase) != 1) begin
      m_perr = 1'b1;
      return;
    end
    if (phase == PF) begin
      m_ipc = m_pc;
      m_pc  = m_pc + 32'd4;
    end else if (phase == PW) begin
      if (trap) begin
        m_epc = m_ipc;
        m_pc  = 32'h80;
      end else if (ret && m_stack.size() > 0) begin
        m_pc = m_stack.pop_back();
      end else if ((ret || ct_taken) && ct_target[1:0] != 2'b00) begin
        m_epc = m_ipc;
        m_pc  = 32'h80;
        m_mis = 1'b1;
      end else if (ret) begin
        m_pc  = ct_target;
        m_err = 1'b1;
      end else if (ct_taken) begin
        if (call) begin
          m_stack.push_back(m_pc);
          if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
        end
        m_pc = ct_target;
      end
    end
  endtask

  task automatic check_all();
    check("pc", pc, m_pc);
    check("ipc", ipc, m_ipc);
    check("epc", epc, m_epc);
    check("ras_empty", {31'b0, ras_empty}, {31'b0, m_stack.size() == 0});
    check("ras_full", {31'b0, ras_full}, {31'b0, m_stack.size() == DEPTH});
    check("ras_err", {31'b0, ras_err}, {31'b0, m_err});
    check("misalign", {31'b0, misalign}, {31'b0, m_mis});
    check("phase_err", {31'b0, phase_err}, {31'b0, m_perr});
  endtask

  task automatic step(input logic [4:0] ph, input logic st, input logic ct,
                      input logic [31:0] tg, input logic cl, input logic rt,
                      input logic tr, input logic rs);
    phase = ph; stall = st; ct_taken = ct; ct_target = tg;
    call = cl; ret = rt; trap = tr; n_rst = rs;
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic cycle(input logic ct, input logic [31:0] tg, input logic cl,
                       input logic rt, input logic tr);
    step(PF, 0, 0, 0, 0, 0, 0, 1);
    step(PR, 0, 0, 0, 0, 0, 0, 1);
    step(PX, 0, 0, 0, 0, 0, 0, 1);
    step(PM, 0, 0, 0, 0, 0, 0, 1);
    step(PW, 0, ct, tg, cl, rt, tr, 1);
  endtask

  initial begin
    logic [4:0]  ph;
    logic [31:0] tg;
    logic [31:0] links[5];

    step(PW, 1, 1, 32'h300, 1, 0, 0, 0);
    check("reset_pc", pc, 32'h0);
    check("reset_empty", {31'b0, ras_empty}, 32'd1);
    check("reset_pc8", {24'b0, s_pc}, 32'hF0);

    // straight-line run
    repeat (3) cycle(0, 0, 0, 0, 0);
    check("seq_pc", pc, 32'h0C);
    check("seq_ipc", ipc, 32'h08);
    check("w8_pc_fc", {24'b0, s_pc}, 32'hFC);
    step(PF, 0, 0, 0, 0, 0, 0, 1);
    check("w8_wrap", {24'b0, s_pc}, 32'h00);
    step(PR, 0, 0, 0, 0, 0, 0, 1);
    step(PX, 0, 0, 0, 0, 0, 0, 1);
    step(PM, 0, 0, 0, 0, 0, 0, 1);
    step(PW, 0, 0, 0, 0, 0, 0, 1);

    // call from pc=0x14, then return
    cycle(1, 32'h100, 1, 0, 0);
    check("call_pc", pc, 32'h100);
    check("call_nonempty", {31'b0, ras_empty}, 32'd0);
    cycle(0, 32'h0, 0, 1, 0);
    check("ret_pc", pc, 32'h14);
    check("ret_empty", {31'b0, ras_empty}, 32'd1);

    // overflow: five calls, four returns, then an underflow
    links = '{32'h18, 32'h204, 32'h304, 32'h404, 32'h504};
    for (int i = 0; i < 5; i++) cycle(1, 32'h200 + 32'h100 * i, 1, 0, 0);
    check("ovf_full", {31'b0, ras_full}, 32'd1);
    for (int i = 4; i >= 1; i--) begin
      cycle(0, 32'h0, 0, 1, 0);
      check($sformatf("ret_L%0d", i + 1), pc, links[i]);
    end
    cycle(0, 32'h40, 0, 1, 0);
    check("udf_pc", pc, 32'h40);
    check("udf_err", {31'b0, ras_err}, 32'd1);

    // priority: trap beats ret and ct_taken, stack untouched
    cycle(1, 32'h1C, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 32'h300, 1, 1, 1);
    check("prio_pc", pc, 32'h80);
    check("prio_epc", epc, 32'h20);
    check("prio_stack", {31'b0, ras_empty}, 32'd0);
    cycle(1, 32'h102, 0, 0, 0);
    check("mis_pc", pc, 32'h80);
    check("mis_flag", {31'b0, misalign}, 32'd1);

    // stall, bad phase, reset during a call
    step(PF, 1, 0, 0, 0, 0, 0, 1);
    check("stall_pc", pc, 32'h80);
    step(5'b00011, 0, 0, 0, 0, 0, 0, 1);
    check("perr_flag", {31'b0, phase_err}, 32'd1);
    check("perr_pc", pc, 32'h80);
    step(PW, 0, 1, 32'h300, 1, 0, 0, 0);
    check("rst_w_pc", pc, 32'h0);
    check("rst_w_empty", {31'b0, ras_empty}, 32'd1);

    // random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 19))
        0: ph = 5'($urandom);
        1, 2, 3: ph = PR << $urandom_range(0, 2);
        4, 5, 6, 7, 8, 9, 10, 11: ph = PF;
        default: ph = PW;
      endcase
      tg = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) tg[1:0] = 2'($urandom_range(1, 3));
      step(ph, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, tg,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 99) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
